drive_sequencer: RTL



---
 rtl/drive_sequencer_pkg.sv | 50 +++++
 rtl/cycle_timer.sv | 39 +++
 rtl/drive_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/drive_sequencer_pkg.sv
// Shared codes for the drive sequencer: motor modes, wheel directions,
// controller states and the remembered turn direction.
package drive_sequencer_pkg;

   // Motor mode codes, identical to the tracker decision encoding
   localparam logic [2:0] MODE_TURN_LEFT   = 3'b000;
   localparam logic [2:0] MODE_TURN_RIGHT  = 3'b001;
   localparam logic [2:0] MODE_STRAIGHT    = 3'b010;
   localparam logic [2:0] MODE_STOP        = 3'b011;
   localparam logic [2:0] MODE_SHARP_LEFT  = 3'b100;
   localparam logic [2:0] MODE_SHARP_RIGHT = 3'b101;

   // Wheel direction codes
   localparam logic [1:0] DIR_FWD = 2'b10;
   localparam logic [1:0] DIR_REV = 2'b01;
   localparam logic [1:0] DIR_OFF = 2'b00;

   // Controller states; codes 5..7 are illegal and fall back to FOLLOW
   typedef enum logic [2:0] {
      ST_FOLLOW    = 3'd0,
      ST_LOST_WAIT = 3'd1,
      ST_SEARCH    = 3'd2,
      ST_OBST      = 3'd3,
      ST_FAULT     = 3'd4
   } ctrl_state_e;

   // Last turn direction seen while following the line
   typedef enum logic {
      TURN_LEFT  = 1'b0,
      TURN_RIGHT = 1'b1
   } last_dir_e;

   // Codes 011, 110 and 111 all mean "no usable line decision"
   function automatic logic is_stop_code(input logic [2:0] code);
      return (code == MODE_STOP) || (code[2:1] == 2'b11);
   endfunction

   // Wheel directions for a mode, packed as {left, right}
   function automatic logic [3:0] wheel_dirs(input logic [2:0] code);
      logic [3:0] dirs;
      case (code)
         MODE_TURN_LEFT, MODE_SHARP_LEFT:   dirs = {DIR_REV, DIR_FWD};
         MODE_TURN_RIGHT, MODE_SHARP_RIGHT: dirs = {DIR_FWD, DIR_REV};
         MODE_STRAIGHT:                     dirs = {DIR_FWD, DIR_FWD};
         default:                           dirs = {DIR_OFF, DIR_OFF};
      endcase
      return dirs;
   endfunction

endpackage

// File: rtl/cycle_timer.sv
// Saturating cycle counter: clr wins over en, done flags count == TARGET-1.
module cycle_timer #(
   parameter int TARGET = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam int W = $clog2(TARGET);
   localparam logic [W-1:0] LAST = W'(TARGET - 1);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear, or step up and hold at the terminal value
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == LAST);

endmodule

// File: rtl/drive_sequencer.sv
// Chooses the mode and wheel directions the car drives with: passes the
// tracker through, holds for obstacles, spin-searches on line loss and
// latches a fault when the search times out.
module drive_sequencer
   import drive_sequencer_pkg::*;
#(
   parameter int LOST_CYCLES   = 5_000_000,
   parameter int SEARCH_CYCLES = 200_000_000,
   parameter int HOLD_CYCLES   = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] track_state,
   input  logic       stop,
   output logic [2:0] mode,
   output logic [1:0] left,
   output logic [1:0] right,
   output logic [2:0] ctrl_state,
   output logic       lost
);

   ctrl_state_e state_q, state_d;
   last_dir_e   last_dir_q, last_dir_d;
   logic [2:0]  mode_q, mode_d, out_mode, search_mode;
   logic [1:0]  left_q, left_d, right_q, right_d;
   logic        lost_q, lost_d;
   logic        track_stop;
   logic        lost_done, search_done, hold_done;
   logic        lost_clr, search_clr, hold_clr;

   assign track_stop  = is_stop_code(track_state);
   assign search_mode = (last_dir_q == TURN_LEFT) ? MODE_SHARP_LEFT : MODE_SHARP_RIGHT;

   // Timer controls: the lost timer counts 1 on the FOLLOW->LOST_WAIT edge;
   // the others start from zero on entry to their state.
   assign lost_clr   = (state_d != ST_LOST_WAIT);
   assign search_clr = (state_q != ST_SEARCH) || (state_d != ST_SEARCH);
   assign hold_clr   = (state_q != ST_OBST) || stop;

   cycle_timer #(.TARGET(LOST_CYCLES)) u_lost_timer (
      .clk (clk), .rst (rst), .clr (lost_clr), .en (1'b1), .done (lost_done)
   );

   cycle_timer #(.TARGET(SEARCH_CYCLES)) u_search_timer (
      .clk (clk), .rst (rst), .clr (search_clr), .en (1'b1), .done (search_done)
   );

   cycle_timer #(.TARGET(HOLD_CYCLES)) u_hold_timer (
      .clk (clk), .rst (rst), .clr (hold_clr), .en (1'b1), .done (hold_done)
   );

   // Next state, next outputs and last turn direction
   always_comb begin
      state_d    = state_q;
      out_mode   = MODE_STOP;
      last_dir_d = last_dir_q;

      case (state_q)
         ST_FOLLOW: begin
            if (track_state == MODE_TURN_LEFT || track_state == MODE_SHARP_LEFT) begin
               last_dir_d = TURN_LEFT;
            end else if (track_state == MODE_TURN_RIGHT || track_state == MODE_SHARP_RIGHT) begin
               last_dir_d = TURN_RIGHT;
            end
            if (stop) begin
               state_d = ST_OBST;
            end else if (track_stop) begin
               state_d = ST_LOST_WAIT;
            end else begin
               out_mode = track_state;
            end
         end
         ST_LOST_WAIT: begin
            if (stop) begin
               state_d = ST_OBST;
            end else if (!track_stop) begin
               state_d  = ST_FOLLOW;
               out_mode = track_state;
            end else if (lost_done) begin
               state_d  = ST_SEARCH;
               out_mode = search_mode;
            end
         end
         ST_SEARCH: begin
            if (stop) begin
               state_d = ST_OBST;
            end else if (!track_stop) begin
               state_d  = ST_FOLLOW;
               out_mode = track_state;
            end else if (search_done) begin
               state_d = ST_FAULT;
            end else begin
               out_mode = search_mode;
            end
         end
         ST_OBST: begin
            if (!stop && hold_done) begin
               state_d = ST_FOLLOW;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_FOLLOW;
         end
      endcase

      mode_d            = out_mode;
      {left_d, right_d} = wheel_dirs(out_mode);
      lost_d            = (state_d == ST_FAULT);
   end

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_FOLLOW;
         last_dir_q <= TURN_LEFT;
         mode_q     <= MODE_STOP;
         left_q     <= DIR_OFF;
         right_q    <= DIR_OFF;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_dir_q <= last_dir_d;
         mode_q     <= mode_d;
         left_q     <= left_d;
         right_q    <= right_d;
         lost_q     <= lost_d;
      end
   end

   assign mode       = mode_q;
   assign left       = left_q;
   assign right      = right_q;
   assign ctrl_state = state_q;
   assign lost       = lost_q;

endmodule
